// File: rtl/logic16_pipe.sv
// Two-stage AND/OR/XOR/NOR responder with zero flag and completed-transaction counter; optional parity via LOGIC16_PARITY_EN.
// Latency: 2 cycles from input fire to out_valid when S2 is free; 1 txn/cycle sustained.
// Backpressure: out_ready low stalls S2, then S1; in_ready depends on out_ready, never on in_valid.
module logic16_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
`ifdef LOGIC16_PARITY_EN
    output logic             parity,
`endif
    output logic [CNT_W-1:0] txn_cnt
);

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [1:0]       op1_q, op1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] res2_q, res2_d;
    logic             zero2_q, zero2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LOGIC16_PARITY_EN
    logic             par2_q, par2_d;
`endif

    logic             adv2;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] res_c;

    assign adv2     = !v2_q || out_ready;
    assign in_ready = !v1_q || adv2;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = v2_q && out_ready;

    always_comb begin
        res_c = '0;
        case (op1_q)
            2'b00:   res_c = x1_q & y1_q;
            2'b01:   res_c = x1_q | y1_q;
            2'b10:   res_c = x1_q ^ y1_q;
            default: res_c = ~(x1_q | y1_q);
        endcase
    end

    always_comb begin
        v1_d    = v1_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        op1_d   = op1_q;
        v2_d    = v2_q;
        res2_d  = res2_q;
        zero2_d = zero2_q;
        cnt_d   = cnt_q;
`ifdef LOGIC16_PARITY_EN
        par2_d  = par2_q;
`endif
        // S1 drains into S2 whenever S2 advances; a new input refills it in the same cycle.
        if (in_fire) begin
            v1_d  = 1'b1;
            x1_d  = x;
            y1_d  = y;
            op1_d = op;
        end else if (adv2) begin
            v1_d  = 1'b0;
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                res2_d  = res_c;
                zero2_d = (res_c == '0);
`ifdef LOGIC16_PARITY_EN
                par2_d  = ^res_c;
`endif
            end
        end
        if (out_fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            op1_q   <= 2'b00;
            v2_q    <= 1'b0;
            res2_q  <= '0;
            zero2_q <= 1'b1;
            cnt_q   <= '0;
`ifdef LOGIC16_PARITY_EN
            par2_q  <= 1'b0;
`endif
        end else begin
            v1_q    <= v1_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            op1_q   <= op1_d;
            v2_q    <= v2_d;
            res2_q  <= res2_d;
            zero2_q <= zero2_d;
            cnt_q   <= cnt_d;
`ifdef LOGIC16_PARITY_EN
            par2_q  <= par2_d;
`endif
        end
    end

    assign out_valid = v2_q;
    assign out       = res2_q;
    assign zero      = zero2_q;
    assign txn_cnt   = cnt_q;
`ifdef LOGIC16_PARITY_EN
    assign parity    = par2_q;
`endif

endmodule
